// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam int          INSTR_BYTES      = 4;
  localparam int          ALIGN_BITS       = $clog2(INSTR_BYTES);
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_out_reg.sv
// One-entry valid/ready output register holding {instr, instr_pc}.
// Priority: clear (flush) > load (new fetch) > drain (consumer took it).
module fetch_out_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             drain_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] pc_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] pc_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] pc_q;

  // Entry update; data is kept on clear, only the valid bit is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      pc_q    <= pc_i;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the architectural PC, talks req/ack to
// instruction memory and feeds decode through a one-entry output register.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (sticky misalign_err and
// forced word alignment of every PC load).
//
// Handshakes: imem_req/imem_ack - a request, once raised, stays up with a
// stable imem_addr until the cycle imem_ack is high (data valid same cycle).
// instr_valid/instr_ready - the instruction transfers on any cycle both are 1.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] next_pc,
  input  logic             flush,
  output logic [WIDTH-1:0] PC,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic             misalign_err,
  output logic [1:0]       dbg_state
);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] req_addr_q;
  logic             outstanding_q;
  logic             pc_load;
  logic             out_load, out_drain, out_clear;

  // A fresh request presents the current PC; a held request keeps its
  // latched address even if a flush has since moved the PC.
  assign imem_addr = outstanding_q ? req_addr_q : pc_q;
  assign PC        = pc_q;
  assign dbg_state = state_q;

  // Next-state and control decode; flush overrides everything else.
  always_comb begin
    state_d   = state_q;
    pc_load   = 1'b0;
    out_load  = 1'b0;
    out_drain = 1'b0;
    out_clear = 1'b0;
    imem_req  = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          out_load = 1'b1;
          pc_load  = 1'b1;
          state_d  = FULL;
        end
      end
      FULL: begin
        if (instr_ready) begin
          imem_req  = ~flush;
          out_drain = 1'b1;
          if (imem_ack) begin
            out_load = 1'b1;
            pc_load  = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
      end
      DRAIN: begin
        imem_req = 1'b1;
        if (imem_ack) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      out_load  = 1'b0;
      out_drain = 1'b0;
      out_clear = 1'b1;
      pc_load   = 1'b1;
      state_d   = (imem_req && !imem_ack) ? DRAIN : FETCH;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  // PC load with forced word alignment and sticky error capture.
  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    if (pc_load) begin
      pc_d = {next_pc[WIDTH-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
      if (next_pc[ALIGN_BITS-1:0] != '0) misalign_d = 1'b1;
    end
  end

  // Sticky error register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end

  assign misalign_err = misalign_q;
`else
  // PC load takes the upstream value unmodified.
  always_comb begin
    pc_d = pc_q;
    if (pc_load) pc_d = next_pc;
  end

  assign misalign_err = 1'b0;
`endif

  // State, PC and request-tracking registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      req_addr_q    <= RESET_PC;
      outstanding_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= imem_req & ~imem_ack;
      if (imem_req) req_addr_q <= imem_addr;
    end
  end

  fetch_out_reg #(.WIDTH(WIDTH)) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (out_load),
    .drain_i (out_drain),
    .clear_i (out_clear),
    .data_i  (imem_rdata),
    .pc_i    (imem_addr),
    .valid_o (instr_valid),
    .data_o  (instr),
    .pc_o    (instr_pc)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency instruction memory.
module tb_fetch_unit;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        flush = 1'b0;
  logic        instr_ready = 1'b1;
  logic        npc_ovr = 1'b0;
  logic [31:0] npc_val = '0;
  int          lat = 0;

  logic [31:0] next_pc, pc, imem_addr, imem_rdata, instr, instr_pc;
  logic        imem_req, imem_ack, instr_valid, misalign_err;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0100)) dut (
    .clk          (clk),
    .rst          (rst),
    .next_pc      (next_pc),
    .flush        (flush),
    .PC           (pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .misalign_err (misalign_err),
    .dbg_state    (dbg_state)
  );

  // memory model: acks after `lat` waiting cycles, data derived from address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  int wait_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst)                       wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                           wait_cnt <= 0;
  end
  assign imem_ack   = imem_req && (wait_cnt >= lat);
  assign imem_rdata = mem_word(imem_addr);
  assign next_pc    = npc_ovr ? npc_val : pc + 32'd4;

  // scoreboard check
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit got_valid;
    // ---------------- reset ----------------
    #1 rst = 1'b1;
    lat = 3;
    step(); step();
    check_eq("rst_pc",       pc,           32'h100);
    check_eq("rst_req",      imem_req,     0);
    check_eq("rst_valid",    instr_valid,  0);
    check_eq("rst_instr",    instr,        0);
    check_eq("rst_instr_pc", instr_pc,     0);
    check_eq("rst_misalign", misalign_err, 0);
    check_eq("rst_state",    dbg_state,    S_IDLE);
    rst = 1'b0;
    #1 check_eq("idle_no_req", imem_req, 0);
    step();
    check_eq("first_req",  imem_req,  1);
    check_eq("first_addr", imem_addr, 32'h100);
    step();
    check_eq("slow_req_hold",  imem_req,  1);
    check_eq("slow_addr_hold", imem_addr, 32'h100);
    rst = 1'b1;
    #1;
    check_eq("midrst_pc",    pc,          32'h100);
    check_eq("midrst_req",   imem_req,    0);
    check_eq("midrst_valid", instr_valid, 0);
    check_eq("midrst_state", dbg_state,   S_IDLE);
    step(); step();

    // ---------------- streaming from 0x0 ----------------
    rst = 1'b0; lat = 0;
    flush = 1'b1; npc_ovr = 1'b1; npc_val = 32'h0;
    step();
    flush = 1'b0; npc_ovr = 1'b0;
    #1;
    check_eq("stream_req0",  imem_req,  1);
    check_eq("stream_addr0", imem_addr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("stream_valid", instr_valid, 1);
      check_eq("stream_ipc",   instr_pc,    32'(4 * i));
      check_eq("stream_instr", instr,       mem_word(32'(4 * i)));
      check_eq("stream_pc",    pc,          32'(4 * i + 4));
    end

    // ---------------- backpressure ----------------
    instr_ready = 1'b0; flush = 1'b1; npc_ovr = 1'b1; npc_val = 32'h0;
    #1 check_eq("flush_full_noreq", imem_req, 0);
    step();
    flush = 1'b0; npc_ovr = 1'b0;
    check_eq("bp_cleared", instr_valid, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", instr_valid, 1);
      check_eq("bp_ipc",   instr_pc,    32'h0);
      check_eq("bp_instr", instr,       mem_word(32'h0));
      check_eq("bp_req",   imem_req,    0);
      check_eq("bp_pc",    pc,          32'h4);
      step();
    end
    instr_ready = 1'b1;
    #1;
    check_eq("release_req",  imem_req,  1);
    check_eq("release_addr", imem_addr, 32'h4);
    step();
    check_eq("release_valid", instr_valid, 1);
    check_eq("release_ipc",   instr_pc,    32'h4);
    check_eq("release_pc",    pc,          32'h8);

    // ---------------- slow memory ----------------
    lat = 3;
    #1;
    check_eq("slow_issue_req",  imem_req,  1);
    check_eq("slow_issue_addr", imem_addr, 32'h8);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("slow_req",   imem_req,    1);
      check_eq("slow_addr",  imem_addr,   32'h8);
      check_eq("slow_valid", instr_valid, 0);
      check_eq("slow_state", dbg_state,   S_FETCH);
    end
    step();
    check_eq("slow_done_valid", instr_valid, 1);
    check_eq("slow_done_ipc",   instr_pc,    32'h8);
    check_eq("slow_done_instr", instr,       mem_word(32'h8));
    check_eq("slow_done_pc",    pc,          32'hC);

    // ---------------- flush with request in flight ----------------
    step();
    check_eq("inflight_state", dbg_state, S_FETCH);
    flush = 1'b1; npc_ovr = 1'b1; npc_val = 32'h200;
    step();
    flush = 1'b0; npc_ovr = 1'b0;
    check_eq("drain_state", dbg_state,   S_DRAIN);
    check_eq("drain_pc",    pc,          32'h200);
    check_eq("drain_valid", instr_valid, 0);
    check_eq("drain_req",   imem_req,    1);
    check_eq("drain_addr",  imem_addr,   32'hC);
    step();
    check_eq("drain_ack_valid", instr_valid, 0);
    check_eq("drain_ack_addr",  imem_addr,   32'hC);
    step();
    check_eq("post_drain_valid", instr_valid, 0);
    check_eq("post_drain_pc",    pc,          32'h200);
    check_eq("post_drain_state", dbg_state,   S_FETCH);
    check_eq("post_drain_addr",  imem_addr,   32'h200);
    got_valid = 1'b0;
    for (int t = 0; t < 10 && !got_valid; t++) begin
      step();
      got_valid = instr_valid;
    end
    check_eq("redirect_valid", got_valid, 1);
    check_eq("redirect_ipc",   instr_pc,  32'h200);
    check_eq("redirect_instr", instr,     mem_word(32'h200));

    // ---------------- misaligned PC load ----------------
    flush = 1'b1; npc_ovr = 1'b1; npc_val = 32'h102;
    step();
    flush = 1'b0; npc_ovr = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    check_eq("mis_pc",  pc,           32'h100);
    check_eq("mis_err", misalign_err, 1);
`else
    check_eq("mis_pc",  pc,           32'h102);
    check_eq("mis_err", misalign_err, 0);
`endif
    repeat (6) step();
`ifdef FETCH_MISALIGN_CHECK_EN
    check_eq("mis_sticky", misalign_err, 1);
`else
    check_eq("mis_sticky", misalign_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
